// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator sequencer.
package csa_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  // Default widths
  localparam int OP_W_DEF  = 11;
  localparam int ACC_W_DEF = 14;
  localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/csa_3to2_stage.sv
// Width-parameterised 3:2 compressor.
// sum = a ^ b ^ c. The carry is the bitwise majority shifted left by one.
// The majority bit that falls off the top is exported, so the caller can
// record the dropped weight-2^W carry.
module csa_3to2_stage #(
  parameter int W = 14
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry_shl,
  output logic         carry_msb
);

  logic [W-1:0] maj;

  // One full-adder cell per bit position
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_fa
      assign sum[gi] = a[gi] ^ b[gi] ^ c[gi];
      assign maj[gi] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
    end
  endgenerate

  assign carry_shl = {maj[W-2:0], 1'b0};
  assign carry_msb = maj[W-1];

endmodule

// File: rtl/csa_accum_seq.sv
// Carry-save accumulator sequencer.
// Operands are reduced one per cycle into a redundant (S, C) pair. When the
// group closes, a single carry-propagate add resolves the pair, and the result
// is held until downstream accepts it.
module csa_accum_seq
  import csa_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  state_t state, state_next;

  logic [ACC_W-1:0] s_acc;
  logic [ACC_W-1:0] c_acc;
  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] csa_sum;
  logic [ACC_W-1:0] csa_carry;
  logic             csa_msb;
  logic [ACC_W:0]   cpa;
  logic [CNT_W-1:0] count;
  logic             ovf_sticky;
  logic             accept;

  // Handshake flags decode from state only, so there is no combinational
  // path from in_valid or out_ready.
  assign in_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
  assign out_valid = (state == ST_OUTPUT);
  assign accept    = in_valid && in_ready;
  assign out_count = count;

  assign x_ext = {{(ACC_W-OP_W){1'b0}}, in_data};

  csa_3to2_stage #(.W(ACC_W)) u_stage (
    .a         (s_acc),
    .b         (c_acc),
    .c         (x_ext),
    .sum       (csa_sum),
    .carry_shl (csa_carry),
    .carry_msb (csa_msb)
  );

  // Carry-propagate add. The extra top bit is the final carry out.
  assign cpa = {1'b0, s_acc} + {1'b0, c_acc};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (accept) state_next = in_last ? ST_RESOLVE : ST_ACCUM;
      end
      ST_RESOLVE: state_next = ST_OUTPUT;
      ST_OUTPUT:  if (out_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Datapath: accumulate on accept, resolve once, then clear after the result handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_acc      <= '0;
      c_acc      <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        s_acc      <= csa_sum;
        c_acc      <= csa_carry;
        ovf_sticky <= ovf_sticky | csa_msb;
        if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
      end
      if (state == ST_RESOLVE) begin
        out_data <= cpa[ACC_W-1:0];
        overflow <= ovf_sticky | cpa[ACC_W];
      end
      if ((state == ST_OUTPUT) && out_ready) begin
        s_acc      <= '0;
        c_acc      <= '0;
        count      <= '0;
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: doc/csa_accum_seq.md
# csa_accum_seq

Sequencer that accumulates a variable-length stream of unsigned operands in carry-save form, one operand per cycle, using a single 3:2 carry-save adder stage, then resolves the redundant sum with one carry-propagate add and presents the result. It sits between an operand source and downstream logic as the controller for the CSA reduction datapath. Both the input and output sides use a valid/ready handshake.

## Interface
- OP_W, default 11: operand width.
- ACC_W, default 14: accumulator and result width. Must satisfy ACC_W > OP_W.
- CNT_W, default 4: width of the operand counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  OP_W  unsigned operand, zero-extended to ACC_W.
- in_last  input  1  marks the final operand of a group; sampled only on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_W  sum of the group, modulo 2^ACC_W.
- out_count  output  CNT_W  number of operands accepted in the group; saturates at 2^CNT_W-1.
- overflow  output  1  the true group sum was ≥ 2^ACC_W.

## Operation
- States:
  - IDLE: S=C=0, counter=0.
  - ACCUM: the group is open.
  - RESOLVE: one cycle; the carry-propagate add runs.
  - OUTPUT: the result is held.
- in_ready = 1 in IDLE and ACCUM only. An accept is in_valid && in_ready.
- On each accept:
  - S ← S ^ C ^ x.
  - C ← maj(S, C, x) << 1, truncated to ACC_W. Here x is in_data zero-extended.
  - count ← count+1, saturating.
  - ovf_sticky |= MSB of maj(S, C, x), i.e. the carry shifted out.
- Transitions:
  - IDLE → ACCUM on an accept with in_last=0.
  - IDLE → RESOLVE on an accept with in_last=1.
  - ACCUM → RESOLVE on an accept with in_last=1.
  - ACCUM stays in ACCUM with no accept; in_valid gaps are legal.
- RESOLVE: {cout, R} ← S + C. Then overflow ← ovf_sticky | cout, and out_data ← R.
- OUTPUT:
  - out_valid = 1, and out_data, out_count and overflow are held stable.
  - On out_valid && out_ready the block goes to IDLE and clears S, C, the counter and ovf_sticky.
- Arithmetic:
  - All operands are unsigned.
  - Dropped carry bits and the CPA carry each represent weight 2^ACC_W, so OR-ing them gives an exact overflow indication.
  - out_data is always the true sum mod 2^ACC_W.
- Empty group: not possible. A group begins only with an accepted operand.
- Count saturation: counting stops at all-ones, and accumulation continues correctly.

## Timing
- Reset values:
  - state=IDLE.
  - in_ready=1 (combinational from state; it is 1 while rst_n is low).
  - out_valid=0, out_data=0, out_count=0, overflow=0.
  - S=C=0.
- Latency: the last operand is accepted at edge k; RESOLVE occupies k..k+1; out_valid rises after edge k+1. The earliest result handshake is at edge k+2.
- Throughput: one operand per cycle while in ACCUM. Two dead cycles per group on the input side with immediate out_ready.
- in_ready is 0 from the edge that accepts in_last until the result handshake completes. A new group's first operand can be accepted in the cycle after the output handshake.
- in_ready and out_valid depend only on state. They have no combinational path from in_valid or out_ready.
- rst_n asserted mid-group (ACCUM, RESOLVE or OUTPUT) discards the partial sum immediately, with no output. After rst_n deasserts the block is in IDLE.

## Structure
- Shared package csa_pkg holds:
  - state encodings: ST_IDLE, ST_ACCUM, ST_RESOLVE, ST_OUTPUT.
  - default width constants OP_W_DEF=11, ACC_W_DEF=14, CNT_W_DEF=4.
- One natural sub-module: csa_3to2_stage. It is a width-parameterised 3:2 compressor with inputs (A, B, C) and outputs (sum, carry-left-shifted, carry_msb_out), and is instantiated once. The CPA is a plain adder in the top level.

## Test plan
- Single operand 5 with in_last=1 from IDLE → out_data=5, out_count=1, overflow=0, out_valid rises two edges after the accept.
- Three back-to-back 2047, last on the third → out_data=6141, out_count=3, overflow=0. in_ready is 0 for exactly the RESOLVE and OUTPUT cycles.
- Nine operands of 2047 → true sum 18423 ≥ 16384, so overflow=1, out_data=2039, out_count=9.
- Twenty operands of 1 with random in_valid gaps, CNT_W=4 → out_data=20 and out_count=15 (saturated).
- out_ready held low for 5 cycles in OUTPUT → out_valid, out_data and overflow stay stable, in_ready=0 throughout. Release → IDLE, and the next group sums independently (e.g. 7+8 gives out_data=15).
- rst_n pulsed low after 3 of 5 operands → all outputs return to reset values immediately. A new group {4, 4} then gives out_data=8, out_count=2.
